// File: rtl/core_avalon_pkg.sv
// -----------------------------------------------------------------------------
// core_avalon_pkg
// Shared definitions for the core request/grant/rvalid to Avalon-MM bridge:
//   - Avalon response codes (avm_response encoding)
//   - response-kind enum used by the bridge's response register
//   - counter-width helper for the outstanding-read counter
// Optional feature macro used by the bridge: CORE_AVALON_BRIDGE_RESPONSE_EN
// -----------------------------------------------------------------------------
package core_avalon_pkg;

  localparam logic [1:0] AVM_RESP_OKAY      = 2'b00;
  localparam logic [1:0] AVM_RESP_RESERVED  = 2'b01;
  localparam logic [1:0] AVM_RESP_SLVERR    = 2'b10;
  localparam logic [1:0] AVM_RESP_DECODEERR = 2'b11;

  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_WRITE = 2'd1,
    RSP_READ  = 2'd2
  } rsp_kind_e;

  // The counter must hold 0..max_outstanding inclusive.
  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/core_avalon_rd_tracker.sv
// -----------------------------------------------------------------------------
// core_avalon_rd_tracker
// Counts Avalon reads in flight and flags readdatavalid arriving with nothing
// outstanding.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rd_accept       a read command was accepted by the slave this cycle
//   rdv             avm_readdatavalid
//   full            rd_cnt == MAX_OUTSTANDING (from the registered count)
//   idle            rd_cnt == 0
//   rsp_read        rdv matched an outstanding read this cycle
//   protocol_err_o  sticky: rdv seen with rd_cnt == 0
// -----------------------------------------------------------------------------
module core_avalon_rd_tracker
  import core_avalon_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_accept,
  input  logic rdv,
  output logic full,
  output logic idle,
  output logic rsp_read,
  output logic protocol_err_o
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             err_q, err_d;

  assign full     = (rd_cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign idle     = (rd_cnt_q == '0);
  assign rsp_read = rdv & ~idle;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q | (rdv & idle);
    // Accept and response in the same cycle cancel out.
    if (rd_accept && !rsp_read) begin
      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end else if (!rd_accept && rsp_read) begin
      rd_cnt_d = rd_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

  assign protocol_err_o = err_q;

endmodule

// File: rtl/core_avalon_bridge.sv
// -----------------------------------------------------------------------------
// core_avalon_bridge
// Converts a core request/grant/rvalid port into a pipelined Avalon-MM master.
// Reads may be pipelined up to MAX_OUTSTANDING deep; writes are only issued
// when no read is in flight, so at most one response is produced per cycle
// and responses stay in order. Writes get a locally generated rvalid.
//
// Handshakes: core_req is held with stable attributes until core_gnt; a
// transfer happens in the cycle where core_req and core_gnt are both high.
// avm_read/avm_write are held while avm_waitrequest is high; the command is
// accepted in the cycle where it is asserted with avm_waitrequest low, which
// is exactly the core_gnt cycle.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   core_req/gnt/addr/we/be/wdata  core request side
//   core_rvalid/rdata            registered response, one per transaction
//   avm_*                        Avalon-MM master
//   protocol_err_o               sticky: readdatavalid with no read pending
// Optional (macro CORE_AVALON_BRIDGE_RESPONSE_EN):
//   avm_response[1:0] input, core_err output registered with core_rvalid.
// -----------------------------------------------------------------------------
module core_avalon_bridge
  import core_avalon_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_req,
  output logic                    core_gnt,
  input  logic [ADDR_WIDTH-1:0]   core_addr,
  input  logic                    core_we,
  input  logic [DATA_WIDTH/8-1:0] core_be,
  input  logic [DATA_WIDTH-1:0]   core_wdata,
  output logic                    core_rvalid,
  output logic [DATA_WIDTH-1:0]   core_rdata,
  output logic [ADDR_WIDTH-1:0]   avm_address,
  output logic                    avm_read,
  output logic                    avm_write,
  output logic [DATA_WIDTH/8-1:0] avm_byteenable,
  output logic [DATA_WIDTH-1:0]   avm_writedata,
  input  logic                    avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]   avm_readdata,
  input  logic                    avm_readdatavalid,
`ifdef CORE_AVALON_BRIDGE_RESPONSE_EN
  input  logic [1:0]              avm_response,
  output logic                    core_err,
`endif
  output logic                    protocol_err_o
);

  logic rd_full, rd_idle, rsp_read;
  logic issue_ok, rd_accept;
  rsp_kind_e rsp_kind;

  logic                  core_rvalid_q, core_rvalid_d;
  logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;

  // Byte offset is dropped: Avalon sees word-aligned addresses.
  logic unused_addr_lo;
  assign unused_addr_lo = ^core_addr[1:0];

  // A write behind outstanding reads would produce a second response in the
  // same cycle as a returning read, so it waits for the read counter to drain.
  assign issue_ok  = core_req & ~rd_full & ~(core_we & ~rd_idle);
  assign avm_read  = issue_ok & ~core_we;
  assign avm_write = issue_ok & core_we;
  assign core_gnt  = issue_ok & ~avm_waitrequest;
  assign rd_accept = avm_read & ~avm_waitrequest;

  assign avm_address    = core_req ? {core_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign avm_byteenable = core_req ? core_be : '0;
  assign avm_writedata  = core_req ? core_wdata : '0;

  core_avalon_rd_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_rd_tracker (
    .clk            (clk),
    .rst            (rst),
    .rd_accept      (rd_accept),
    .rdv            (avm_readdatavalid),
    .full           (rd_full),
    .idle           (rd_idle),
    .rsp_read       (rsp_read),
    .protocol_err_o (protocol_err_o)
  );

  // Write grant and read response are mutually exclusive by construction.
  always_comb begin
    rsp_kind = RSP_NONE;
    if (avm_write && !avm_waitrequest) begin
      rsp_kind = RSP_WRITE;
    end else if (rsp_read) begin
      rsp_kind = RSP_READ;
    end
  end

  always_comb begin
    core_rvalid_d = (rsp_kind != RSP_NONE);
    core_rdata_d  = core_rdata_q;
    case (rsp_kind)
      RSP_READ:  core_rdata_d = avm_readdata;
      RSP_WRITE: core_rdata_d = '0;
      default:   core_rdata_d = core_rdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
    end else begin
      core_rvalid_q <= core_rvalid_d;
      core_rdata_q  <= core_rdata_d;
    end
  end

  assign core_rvalid = core_rvalid_q;
  assign core_rdata  = core_rdata_q;

`ifdef CORE_AVALON_BRIDGE_RESPONSE_EN
  logic core_err_q, core_err_d;

  assign core_err_d = (rsp_kind == RSP_READ) && (avm_response != AVM_RESP_OKAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_err_q <= 1'b0;
    end else begin
      core_err_q <= core_err_d;
    end
  end

  assign core_err = core_err_q;
`endif

endmodule

// File: tb/tb_core_avalon_bridge.sv
// -----------------------------------------------------------------------------
// tb_core_avalon_bridge
// Drives core transactions, models an Avalon slave with a small memory, and
// checks in-order responses against a reference memory through an expected
// queue popped by an independent monitor.
// -----------------------------------------------------------------------------
module tb_core_avalon_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          core_req = 1'b0;
  logic          core_gnt;
  logic [AW-1:0] core_addr = '0;
  logic          core_we = 1'b0;
  logic [BW-1:0] core_be = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_rvalid;
  logic [DW-1:0] core_rdata;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [BW-1:0] avm_byteenable;
  logic [DW-1:0] avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic          avm_readdatavalid = 1'b0;
  logic          protocol_err_o;
`ifdef CORE_AVALON_BRIDGE_RESPONSE_EN
  logic [1:0]    avm_response = 2'b00;
  logic          core_err;
`endif

  core_avalon_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_gnt(core_gnt), .core_addr(core_addr),
    .core_we(core_we), .core_be(core_be), .core_wdata(core_wdata),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
`ifdef CORE_AVALON_BRIDGE_RESPONSE_EN
    .avm_response(avm_response), .core_err(core_err),
`endif
    .protocol_err_o(protocol_err_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int last_gnt_cyc = -1;
  int last_rdv_cyc = -1;

  // {err, data}
  logic [DW:0] exp_q[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] slv_mem [16];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Reads return an error response code derived from the address.
  function automatic logic [1:0] resp_of(input logic [AW-1:0] a);
    return a[5:4];
  endfunction

  // ---------------- Avalon slave model ----------------
  int  wait_hold = 0;
  bit  no_wait = 1'b1;
  bit  hold_data = 1'b0;
  int  fixed_lat = 0;
  bit  spur_req = 1'b0;
  logic [DW-1:0] pend_data[$];
  logic [1:0]    pend_resp[$];
  int            pend_ready[$];

  initial forever begin
    @(posedge clk);
    #2;
    if (wait_hold > 0) begin
      avm_waitrequest = 1'b1;
      wait_hold--;
    end else if (no_wait) avm_waitrequest = 1'b0;
    else avm_waitrequest = ($urandom_range(0, 3) == 0);
    avm_readdatavalid = 1'b0;
    avm_readdata = $urandom;
    if (spur_req) begin
      avm_readdatavalid = 1'b1;
      spur_req = 1'b0;
    end else if (!hold_data && pend_data.size() > 0 && cyc >= pend_ready[0] &&
                 (fixed_lat != 0 || $urandom_range(0, 1) == 1)) begin
      avm_readdata = pend_data.pop_front();
      void'(pend_ready.pop_front());
`ifdef CORE_AVALON_BRIDGE_RESPONSE_EN
      avm_response = pend_resp.pop_front();
`else
      void'(pend_resp.pop_front());
`endif
      avm_readdatavalid = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (avm_read && !avm_waitrequest) begin
        pend_data.push_back(slv_mem[avm_address[5:2]]);
        pend_resp.push_back(resp_of(avm_address));
        pend_ready.push_back(cyc + ((fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4)));
      end
      if (avm_write && !avm_waitrequest)
        slv_mem[avm_address[5:2]] = merge(slv_mem[avm_address[5:2]], avm_writedata, avm_byteenable);
    end
  end

  // ---------------- monitor / reference ----------------
  int   inflight = 0;
  bit   rvalid_exp = 1'b0;
  bit   err_exp = 1'b0;
  logic [DW-1:0] last_rdata = '0;

  initial forever begin
    @(negedge clk or posedge rst);
    if (rst) begin
      exp_q.delete();
      inflight = 0;
      rvalid_exp = 1'b0;
      err_exp = 1'b0;
      last_rdata = '0;
    end else begin
      logic exp_rd, exp_wr, rsp_ok;
      logic [DW:0] e;
      chk(core_rvalid == rvalid_exp, "rvalid_timing", core_rvalid, rvalid_exp);
      if (core_rvalid) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "rvalid_unexpected", core_rdata, 0);
        end else begin
          e = exp_q.pop_front();
          chk(core_rdata == e[DW-1:0], "rdata", core_rdata, e[DW-1:0]);
`ifdef CORE_AVALON_BRIDGE_RESPONSE_EN
          chk(core_err == e[DW], "core_err", core_err, e[DW]);
`endif
          last_rdata = e[DW-1:0];
        end
      end else begin
        chk(core_rdata == last_rdata, "rdata_hold", core_rdata, last_rdata);
      end
      chk(protocol_err_o == err_exp, "protocol_err", protocol_err_o, err_exp);

      exp_rd = core_req && !core_we && (inflight < MAX);
      exp_wr = core_req && core_we && (inflight == 0);
      chk(avm_read == exp_rd, "avm_read", avm_read, exp_rd);
      chk(avm_write == exp_wr, "avm_write", avm_write, exp_wr);
      chk(core_gnt == ((exp_rd || exp_wr) && !avm_waitrequest), "core_gnt", core_gnt,
          (exp_rd || exp_wr) && !avm_waitrequest);

      rsp_ok = avm_readdatavalid && (inflight > 0);
      if (avm_readdatavalid && inflight == 0) err_exp = 1'b1;
      rvalid_exp = (exp_wr && !avm_waitrequest) || rsp_ok;
      if (rsp_ok) last_rdv_cyc = cyc;
      inflight = inflight + ((exp_rd && !avm_waitrequest) ? 1 : 0) - (rsp_ok ? 1 : 0);
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the grant.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                       input logic [DW-1:0] wdata, output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    core_req = 1'b1;
    core_we = we;
    core_addr = addr;
    core_be = be;
    core_wdata = wdata;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (core_gnt) begin
        got = 1'b1;
        grant_cnt++;
        last_gnt_cyc = cyc;
        chk(avm_address == {addr[AW-1:2], 2'b00}, "avm_address", avm_address, {addr[AW-1:2], 2'b00});
        if (we) begin
          chk(avm_byteenable == be, "avm_byteenable", avm_byteenable, be);
          chk(avm_writedata == wdata, "avm_writedata", avm_writedata, wdata);
          ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], wdata, be);
          exp_q.push_back({1'b0, {DW{1'b0}}});
        end else begin
          exp_q.push_back({resp_of(addr) != 2'b00, ref_mem[addr[5:2]]});
        end
      end else begin
        waited++;
      end
    end
    if (!got) chk(1'b0, "grant_timeout", waited, 0);
    @(posedge clk);
    #1;
    core_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    chk(core_rvalid == 1'b0, "async_rst_rvalid", core_rvalid, 0);
    chk(core_rdata == '0, "async_rst_rdata", core_rdata, 0);
    chk(protocol_err_o == 1'b0, "async_rst_err", protocol_err_o, 0);
    #1 rst = 1'b0;
    idle(1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || pend_data.size() > 0) && n < 400) begin
      idle(1);
      n++;
    end
    chk(exp_q.size() == 0, name, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int  w;
  int  burst_w;
  bit  burst_done = 1'b0;
  int  base;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
      slv_mem[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk(core_rvalid == 1'b0, "reset_rvalid", core_rvalid, 0);
    chk(core_rdata == '0, "reset_rdata", core_rdata, 0);
    chk(protocol_err_o == 1'b0, "reset_err", protocol_err_o, 0);
    chk({core_gnt, avm_read, avm_write} == 3'b000, "reset_cmd", {core_gnt, avm_read, avm_write}, 0);
    chk(avm_address == '0, "reset_addr", avm_address, 0);
    #1 rst = 1'b0;
    idle(1);

    // Single write with zero-cycle grant.
    no_wait = 1'b1;
    issue(1'b1, 32'h1003, 4'b0010, 32'hDEADBEEF, w);
    chk(w == 0, "write_zero_wait", w, 0);
    idle(2);

    // Read stalled by waitrequest for 3 cycles, data 2 cycles after accept.
    wait_hold = 3;
    fixed_lat = 2;
    issue(1'b0, 32'h1000, 4'hF, '0, w);
    chk(w == 3, "read_wait_cycles", w, 3);
    drain("read_drain");

    // Six back-to-back reads against a slave that withholds data.
    hold_data = 1'b1;
    fixed_lat = 1;
    base = grant_cnt;
    fork
      begin
        for (int k = 0; k < 6; k++) issue(1'b0, 32'h4 * k, 4'hF, '0, burst_w);
        burst_done = 1'b1;
      end
    join_none
    for (int i = 0; i < 50 && grant_cnt < base + 4; i++) idle(1);
    idle(10);
    chk(grant_cnt == base + 4, "full_stall_grants", grant_cnt - base, 4);
    hold_data = 1'b0;
    for (int i = 0; i < 300 && !burst_done; i++) idle(1);
    chk(burst_done, "full_burst_done", burst_done, 1);
    drain("full_drain");

    // Write behind an outstanding read waits for the counter to drain.
    fixed_lat = 3;
    issue(1'b0, 32'h8, 4'hF, '0, w);
    issue(1'b1, 32'h8, 4'b1001, 32'h55AA33CC, w);
    chk(last_gnt_cyc == last_rdv_cyc + 1, "write_after_read", last_gnt_cyc, last_rdv_cyc + 1);
    issue(1'b0, 32'h8, 4'hF, '0, w);
    issue(1'b0, 32'h20, 4'hF, '0, w);
    drain("war_drain");

    // Spurious readdatavalid at idle.
    spur_req = 1'b1;
    idle(3);
    chk(protocol_err_o == 1'b1, "spurious_err_set", protocol_err_o, 1);
    idle(5);
    chk(protocol_err_o == 1'b1, "spurious_err_sticky", protocol_err_o, 1);
    pulse_reset();

    // Reset with a read in flight; the late data is a protocol error.
    hold_data = 1'b1;
    fixed_lat = 1;
    issue(1'b0, 32'h10, 4'hF, '0, w);
    idle(2);
    pulse_reset();
    hold_data = 1'b0;
    idle(6);
    chk(protocol_err_o == 1'b1, "late_rdv_err", protocol_err_o, 1);
    chk(pend_data.size() == 0, "late_rdv_consumed", pend_data.size(), 0);
    pulse_reset();

    // Randomized traffic.
    no_wait = 1'b0;
    fixed_lat = 0;
    for (int t = 0; t < 150; t++) begin
      issue(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(1, 15)), $urandom, w);
      idle($urandom_range(0, 2));
    end
    drain("random_drain");
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_avalon_bridge.md
Name: core_avalon_bridge

Overview:
- Converts the core's LSU or instruction request/grant/rvalid port into a pipelined Avalon-MM master for the Qsys interconnect.
- Sits directly downstream of the core wrapper's lsu_* (or instr_*) port. One instance is used per port.
- Tracks outstanding reads, preserves in-order responses, and generates the rvalid that Avalon writes lack.

Parameters:
- ADDR_WIDTH, 32, core and Avalon byte-address width.
- DATA_WIDTH, 32, data width; byteenable is DATA_WIDTH/8 bits.
- MAX_OUTSTANDING, 4, maximum number of reads in flight (at least 1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- core_req  in  1  request from core; held with stable attributes until granted
- core_gnt  out  1  request accepted this cycle
- core_addr  in  ADDR_WIDTH  byte address
- core_we  in  1  1 = write
- core_be  in  DATA_WIDTH/8  byte enables
- core_wdata  in  DATA_WIDTH  write data
- core_rvalid  out  1  response valid, one cycle per accepted transaction
- core_rdata  out  DATA_WIDTH  read data (0 for write responses)
- avm_address  out  ADDR_WIDTH  word-aligned byte address
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_byteenable  out  DATA_WIDTH/8
- avm_writedata  out  DATA_WIDTH
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_WIDTH
- avm_readdatavalid  in  1
- protocol_err_o  out  1  sticky: readdatavalid received with no read outstanding

Behaviour:
- Reset (rst high, async): read counter 0, core_rvalid 0, core_rdata 0, protocol_err_o 0. Combinational outputs are forced low while outstanding state is 0 and core_req is 0.
- Issue enable: issue_ok = core_req & ~full & ~(core_we & rd_cnt != 0), where full = (rd_cnt == MAX_OUTSTANDING).
- Writes are never issued while any read is outstanding. This guarantees at most one response per cycle.
- Command outputs:
  - avm_read = issue_ok & ~core_we
  - avm_write = issue_ok & core_we
  - avm_address = {core_addr[ADDR_WIDTH-1:2], 2'b00}
  - byteenable and writedata pass through combinationally.
- Grant: core_gnt = issue_ok & ~avm_waitrequest. Zero-cycle grant when the slave is ready.
- Accepted read: rd_cnt increments.
- Response: readdatavalid with rd_cnt > 0 decrements rd_cnt. The same cycle can accept a read and receive readdatavalid; the counter then holds.
- core_rvalid is registered: set the cycle after a write grant or an accepted readdatavalid, otherwise 0.
- core_rdata is registered: avm_readdata on a read response, 0 on a write response, otherwise it holds its previous value.
- Minimum latency: write 1 cycle after gnt; read 1 cycle after readdatavalid.
- Boundaries:
  - full: core_gnt stays 0 and avm_read is not asserted until a response frees a slot. When full with a simultaneous response, no new issue in that cycle (full is computed from the registered count).
  - Write following reads: stalled until rd_cnt = 0.
  - readdatavalid with rd_cnt = 0: ignored, no rvalid, protocol_err_o set until reset.
  - Reset mid-transaction: all state cleared immediately. Late readdatavalid after reset sets protocol_err_o.

Optional Feature:
- Macro: CORE_AVALON_BRIDGE_RESPONSE_EN.
- When defined:
  - Adds input avm_response[1:0] and output core_err.
  - core_err is registered alongside core_rvalid, = (avm_response != 2'b00) on read responses, 0 on writes.
- When undefined: no such ports; errors are not reported.

Decomposition:
- Package core_avalon_pkg:
  - AVM_RESP_OKAY/RESERVED/SLVERR/DECODEERR constants.
  - Function clog2-based counter width for MAX_OUTSTANDING.
  - Typedef for response-kind enum {RSP_NONE, RSP_WRITE, RSP_READ}.
- Sub-module core_avalon_rd_tracker: owns rd_cnt, full, and protocol_err_o. The top module handles issue, grant, and the response register.

Test Plan:
- Single write, waitrequest=0: addr 0x1003, be 4'b0010, wdata 0xDEADBEEF -> same cycle: avm_write=1, avm_address=0x1000, core_gnt=1; next cycle: core_rvalid=1, core_rdata=0.
- Read with waitrequest held high 3 cycles, then readdatavalid 2 cycles after accept with 0x12345678 -> core_gnt only in the 4th cycle, avm_read held throughout, core_rvalid=1 with 0x12345678 one cycle after readdatavalid.
- Back-to-back 6 reads, MAX_OUTSTANDING=4, slave withholds data -> exactly 4 grants, then core_gnt=0. After 1 readdatavalid, a 5th grant follows. All 6 rdata values are returned in order.
- Read outstanding, then core writes -> core_gnt=0 and avm_write=0 until readdatavalid. Write grant happens the cycle after rd_cnt reaches 0.
- Spurious readdatavalid at idle -> no core_rvalid, protocol_err_o=1 and sticky. Asserting rst clears it asynchronously.
- With CORE_AVALON_BRIDGE_RESPONSE_EN defined: read response 2'b10 -> core_err=1 with core_rvalid. Write response -> core_err=0.
